// File: rtl/sata_pkg.sv
// Shared definitions for the SATA command layer: FIS/command codes, state encoding.
// Latency: n/a (package).
// Backpressure: n/a (package).
package sata_pkg;

    localparam logic [7:0] FIS_TYPE_REG_H2D  = 8'h27;
    localparam logic [7:0] CMD_READ_DMA_EXT  = 8'h25;
    localparam logic [7:0] CMD_WRITE_DMA_EXT = 8'h35;

    localparam int DWORDS_PER_SECTOR_DEFAULT = 128;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND_FIS = 3'd1,
        ST_DATA_WR  = 3'd2,
        ST_DATA_RD  = 3'd3,
        ST_STATUS   = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    // ERR (bit 0) or DF (bit 5) in the status byte, or any error bit, fails the command.
    function automatic logic status_is_error(input logic [7:0] status, input logic [7:0] error);
        return status[0] | status[5] | (error != 8'd0);
    endfunction

endpackage

// File: rtl/sata_h2d_fis_builder.sv
// Builds one dword of a Register Host-to-Device FIS from the latched command fields.
// Latency: combinational.
// Backpressure: none; the caller holds index stable while the transport stalls.
module sata_h2d_fis_builder
    import sata_pkg::*;
(
    input  logic [2:0]  index,
    input  logic [7:0]  cmd,
    input  logic [47:0] lba,
    input  logic [15:0] count,
    output logic [31:0] dword
);

    // Select the FIS dword for the current index; the device register byte sets LBA mode.
    always_comb begin
        dword = 32'h0;
        case (index)
            3'd0:    dword = {8'h00, cmd, 8'h80, FIS_TYPE_REG_H2D};
            3'd1:    dword = {8'h40, lba[23:0]};
            3'd2:    dword = {8'h00, lba[47:24]};
            3'd3:    dword = {16'h0000, count};
            default: dword = 32'h0;
        endcase
    end

endmodule

// File: rtl/sata_command_engine.sv
// Command-layer responder: latches a command, sends the H2D FIS, counts DMA dwords, waits for D2H status.
// Latency: busy the cycle after the strobe; FIS phase at least 5 cycles; done one cycle after status.
// Backpressure: FIS dword and index hold while fis_tx_ready is low; data phase paced by transport strobes.
module sata_command_engine
    import sata_pkg::*;
#(
    parameter int DWORDS_PER_SECTOR = DWORDS_PER_SECTOR_DEFAULT,
    parameter int MAX_SECTORS       = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [7:0]  sata_command,
    input  logic        sata_execute_command_stb,
    input  logic [47:0] sata_lba,
    input  logic [15:0] sata_sector_count,
    output logic        sata_busy,
    output logic [31:0] fis_tx_data,
    output logic        fis_tx_valid,
    output logic        fis_tx_last,
    input  logic        fis_tx_ready,
    input  logic        wr_strobe,
    input  logic        rd_strobe,
    input  logic        d2h_valid,
    input  logic [7:0]  d2h_status,
    input  logic [7:0]  d2h_error,
    output logic        cmd_done,
    output logic        cmd_error,
    output logic [7:0]  cmd_status
);

    localparam int SECTOR_SHIFT = $clog2(DWORDS_PER_SECTOR);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  cmd_q;
    logic [47:0] lba_q;
    logic [15:0] count_q;
    logic [23:0] total_dwords;
    logic [23:0] dword_count;
    logic [2:0]  fis_index;
    logic [31:0] fis_dword;
    logic [23:0] sectors_eff;
    logic        data_strobe;
    logic        last_strobe;
    logic        fis_accept;
    logic        load_cmd;
    logic        count_inc;
    logic        capture_normal;
    logic        capture_early;

    // A zero sector count means the largest transfer the protocol allows.
    assign sectors_eff = (sata_sector_count == 16'd0) ? 24'(MAX_SECTORS) : {8'd0, sata_sector_count};
    assign data_strobe = (state == ST_DATA_WR) ? wr_strobe : rd_strobe;
    assign last_strobe = data_strobe && ((dword_count + 24'd1) == total_dwords);
    assign fis_accept  = (state == ST_SEND_FIS) && fis_tx_ready;

    sata_h2d_fis_builder u_fis_builder (
        .index (fis_index),
        .cmd   (cmd_q),
        .lba   (lba_q),
        .count (count_q),
        .dword (fis_dword)
    );

    // State register; disabling the block aborts straight to IDLE.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the datapath control strobes it implies.
    always_comb begin
        state_nxt      = state;
        load_cmd       = 1'b0;
        count_inc      = 1'b0;
        capture_normal = 1'b0;
        capture_early  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sata_execute_command_stb) begin
                    load_cmd  = 1'b1;
                    state_nxt = ST_SEND_FIS;
                end
            end
            ST_SEND_FIS: begin
                if (fis_accept && (fis_index == 3'd4)) begin
                    case (cmd_q)
                        CMD_WRITE_DMA_EXT: state_nxt = ST_DATA_WR;
                        CMD_READ_DMA_EXT:  state_nxt = ST_DATA_RD;
                        default:           state_nxt = ST_STATUS;
                    endcase
                end
            end
            ST_DATA_WR, ST_DATA_RD: begin
                if (dword_count == total_dwords) begin
                    // Transfer complete: any status now is the normal response.
                    if (d2h_valid) begin
                        capture_normal = 1'b1;
                        state_nxt      = ST_DONE;
                    end else begin
                        state_nxt = ST_STATUS;
                    end
                end else if (d2h_valid) begin
                    // Status alongside the final strobe is a normal finish, otherwise the device cut us short.
                    capture_normal = last_strobe;
                    capture_early  = !last_strobe;
                    state_nxt      = ST_DONE;
                end else if (data_strobe) begin
                    count_inc = 1'b1;
                end
            end
            ST_STATUS: begin
                if (d2h_valid) begin
                    capture_normal = 1'b1;
                    state_nxt      = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: command latch, FIS index, dword counter and completion status.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            cmd_q        <= 8'd0;
            lba_q        <= 48'd0;
            count_q      <= 16'd0;
            total_dwords <= 24'd0;
            dword_count  <= 24'd0;
            fis_index    <= 3'd0;
            cmd_error    <= 1'b0;
            cmd_status   <= 8'd0;
        end else begin
            if (load_cmd) begin
                cmd_q        <= sata_command;
                lba_q        <= sata_lba;
                count_q      <= sata_sector_count;
                total_dwords <= sectors_eff << SECTOR_SHIFT;
                dword_count  <= 24'd0;
                fis_index    <= 3'd0;
                cmd_error    <= 1'b0;
            end
            if (fis_accept) begin
                fis_index <= (fis_index == 3'd4) ? 3'd0 : fis_index + 3'd1;
            end
            if (count_inc) begin
                dword_count <= dword_count + 24'd1;
            end
            if (capture_normal) begin
                cmd_status <= d2h_status;
                cmd_error  <= status_is_error(d2h_status, d2h_error);
            end
            if (capture_early) begin
                cmd_status <= d2h_status;
                cmd_error  <= 1'b1;
            end
        end
    end

    // Outputs decoded from state; FIS data is forced to zero outside the FIS phase.
    always_comb begin
        sata_busy    = (state == ST_SEND_FIS) || (state == ST_DATA_WR) ||
                       (state == ST_DATA_RD)  || (state == ST_STATUS);
        fis_tx_valid = (state == ST_SEND_FIS);
        fis_tx_last  = (state == ST_SEND_FIS) && (fis_index == 3'd4);
        fis_tx_data  = (state == ST_SEND_FIS) ? fis_dword : 32'h0;
        cmd_done     = (state == ST_DONE);
    end

endmodule

// File: tb/tb_sata_command_engine.sv
// Directed bench for sata_command_engine; MAX_SECTORS is reduced so the zero-count path stays short.
// Latency: n/a (testbench).
// Backpressure: fis_tx_ready driven high or randomly toggled per scenario.
module tb_sata_command_engine;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [7:0]  sata_command;
    logic        sata_execute_command_stb;
    logic [47:0] sata_lba;
    logic [15:0] sata_sector_count;
    logic        sata_busy;
    logic [31:0] fis_tx_data;
    logic        fis_tx_valid;
    logic        fis_tx_last;
    logic        fis_tx_ready;
    logic        wr_strobe;
    logic        rd_strobe;
    logic        d2h_valid;
    logic [7:0]  d2h_status;
    logic [7:0]  d2h_error;
    logic        cmd_done;
    logic        cmd_error;
    logic [7:0]  cmd_status;

    int checks = 0;
    int errors = 0;

    // Zero count selects 64 sectors * 128 = 8192 dwords here.
    sata_command_engine #(
        .DWORDS_PER_SECTOR (128),
        .MAX_SECTORS       (64)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .enable                   (enable),
        .sata_command             (sata_command),
        .sata_execute_command_stb (sata_execute_command_stb),
        .sata_lba                 (sata_lba),
        .sata_sector_count        (sata_sector_count),
        .sata_busy                (sata_busy),
        .fis_tx_data              (fis_tx_data),
        .fis_tx_valid             (fis_tx_valid),
        .fis_tx_last              (fis_tx_last),
        .fis_tx_ready             (fis_tx_ready),
        .wr_strobe                (wr_strobe),
        .rd_strobe                (rd_strobe),
        .d2h_valid                (d2h_valid),
        .d2h_status               (d2h_status),
        .d2h_error                (d2h_error),
        .cmd_done                 (cmd_done),
        .cmd_error                (cmd_error),
        .cmd_status               (cmd_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] c, input logic [47:0] l, input logic [15:0] n);
        sata_command             = c;
        sata_lba                 = l;
        sata_sector_count        = n;
        sata_execute_command_stb = 1'b1;
        tick();
        sata_execute_command_stb = 1'b0;
    endtask

    task automatic pass_fis;
        fis_tx_ready = 1'b1;
        repeat (5) tick();
    endtask

    task automatic send_status(input logic [7:0] st, input logic [7:0] er);
        d2h_valid  = 1'b1;
        d2h_status = st;
        d2h_error  = er;
        tick();
        d2h_valid  = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({sata_busy, fis_tx_valid, fis_tx_last, cmd_done, cmd_error, cmd_status, fis_tx_data} !== 44'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b valid=%b last=%b done=%b err=%b status=%h data=%h, need all zero",
                     sata_busy, fis_tx_valid, fis_tx_last, cmd_done, cmd_error, cmd_status, fis_tx_data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write;
        logic [31:0] exp [5];
        exp[0] = 32'h0035_8027;
        exp[1] = 32'h4034_5678;
        exp[2] = 32'h0000_0012;
        exp[3] = 32'h0000_0002;
        exp[4] = 32'h0000_0000;
        fis_tx_ready = 1'b1;
        issue(8'h35, 48'h0000_1234_5678, 16'd2);
        checks++;
        if (sata_busy !== 1'b1) begin
            errors++;
            $display("FAIL write_busy_rise: got %b need 1", sata_busy);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (fis_tx_valid !== 1'b1 || fis_tx_data !== exp[i] || fis_tx_last !== (i == 4)) begin
                errors++;
                $display("FAIL write_fis_dw%0d: got valid=%b data=%h last=%b need 1 %h %b",
                         i, fis_tx_valid, fis_tx_data, fis_tx_last, exp[i], (i == 4));
            end
            tick();
        end
        checks++;
        if (fis_tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL write_fis_end: got valid=%b need 0", fis_tx_valid);
        end
        wr_strobe = 1'b1;
        repeat (256) tick();
        wr_strobe = 1'b0;
        tick();
        tick();
        checks++;
        if (sata_busy !== 1'b1 || cmd_done !== 1'b0) begin
            errors++;
            $display("FAIL write_wait_status: got busy=%b done=%b need 1 0", sata_busy, cmd_done);
        end
        send_status(8'h50, 8'h00);
        checks++;
        if (cmd_done !== 1'b1 || sata_busy !== 1'b0 || cmd_error !== 1'b0 || cmd_status !== 8'h50) begin
            errors++;
            $display("FAIL write_done: got done=%b busy=%b err=%b status=%h need 1 0 0 50",
                     cmd_done, sata_busy, cmd_error, cmd_status);
        end
        tick();
        checks++;
        if (cmd_done !== 1'b0) begin
            errors++;
            $display("FAIL write_done_pulse: got %b need 0", cmd_done);
        end
    endtask

    task automatic test_read_max;
        // Stop one dword short with stray write strobes first: must be an early termination.
        issue(8'h25, 48'h0000_0000_1000, 16'd0);
        pass_fis();
        wr_strobe = 1'b1;
        repeat (40) tick();
        wr_strobe = 1'b0;
        rd_strobe = 1'b1;
        repeat (8191) tick();
        rd_strobe = 1'b0;
        repeat (3) tick();
        checks++;
        if (sata_busy !== 1'b1) begin
            errors++;
            $display("FAIL read_max_busy_short: got %b need 1", sata_busy);
        end
        send_status(8'h50, 8'h00);
        checks++;
        if (cmd_done !== 1'b1 || cmd_error !== 1'b1) begin
            errors++;
            $display("FAIL read_max_short_term: got done=%b err=%b need 1 1", cmd_done, cmd_error);
        end
        tick();
        // Full 8192-dword transfer then status: normal completion.
        issue(8'h25, 48'h0000_0000_2000, 16'd0);
        pass_fis();
        rd_strobe = 1'b1;
        repeat (8192) tick();
        rd_strobe = 1'b0;
        repeat (4) tick();
        checks++;
        if (sata_busy !== 1'b1 || cmd_done !== 1'b0) begin
            errors++;
            $display("FAIL read_max_wait_status: got busy=%b done=%b need 1 0", sata_busy, cmd_done);
        end
        send_status(8'h50, 8'h00);
        checks++;
        if (cmd_done !== 1'b1 || cmd_error !== 1'b0 || sata_busy !== 1'b0) begin
            errors++;
            $display("FAIL read_max_done: got done=%b err=%b busy=%b need 1 0 0", cmd_done, cmd_error, sata_busy);
        end
        tick();
    endtask

    task automatic test_final_strobe_with_status;
        issue(8'h25, 48'h0000_0000_0040, 16'd1);
        pass_fis();
        rd_strobe = 1'b1;
        repeat (127) tick();
        d2h_valid  = 1'b1;
        d2h_status = 8'h50;
        d2h_error  = 8'h00;
        tick();
        rd_strobe = 1'b0;
        d2h_valid = 1'b0;
        checks++;
        if (cmd_done !== 1'b1 || cmd_error !== 1'b0 || cmd_status !== 8'h50) begin
            errors++;
            $display("FAIL final_strobe_status: got done=%b err=%b status=%h need 1 0 50",
                     cmd_done, cmd_error, cmd_status);
        end
        tick();
    endtask

    task automatic test_random_ready;
        logic [31:0] exp [5];
        int hs;
        int cyc;
        exp[0] = 32'h00EC_8027;
        exp[1] = 32'h4001_2345;
        exp[2] = 32'h00AB_CDEF;
        exp[3] = 32'h0000_0003;
        exp[4] = 32'h0000_0000;
        hs  = 0;
        cyc = 0;
        issue(8'hEC, 48'hABCD_EF01_2345, 16'd3);
        while (fis_tx_valid === 1'b1 && cyc < 200) begin
            fis_tx_ready = 1'($urandom_range(0, 1));
            sata_execute_command_stb = (cyc == 2);
            sata_command = 8'h25;
            checks++;
            if (hs > 4 || fis_tx_data !== exp[hs] || fis_tx_last !== (hs == 4)) begin
                errors++;
                $display("FAIL rand_fis_hold: handshake %0d got data=%h last=%b", hs, fis_tx_data, fis_tx_last);
            end
            if (fis_tx_ready) hs++;
            tick();
            cyc++;
        end
        sata_execute_command_stb = 1'b0;
        fis_tx_ready = 1'b1;
        checks++;
        if (hs != 5 || sata_busy !== 1'b1) begin
            errors++;
            $display("FAIL rand_fis_handshakes: got %0d handshakes busy=%b need 5 1", hs, sata_busy);
        end
        tick();
        send_status(8'h51, 8'h00);
        checks++;
        if (cmd_done !== 1'b1 || cmd_error !== 1'b1 || cmd_status !== 8'h51) begin
            errors++;
            $display("FAIL nondata_status: got done=%b err=%b status=%h need 1 1 51", cmd_done, cmd_error, cmd_status);
        end
        tick();
        tick();
        checks++;
        if (sata_busy !== 1'b0 || fis_tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL ignored_strobe: got busy=%b valid=%b need 0 0", sata_busy, fis_tx_valid);
        end
    endtask

    task automatic test_early_term;
        issue(8'h35, 48'h0000_0000_0100, 16'd1);
        pass_fis();
        wr_strobe = 1'b1;
        repeat (10) tick();
        wr_strobe = 1'b0;
        send_status(8'h50, 8'h00);
        checks++;
        if (cmd_done !== 1'b1 || cmd_error !== 1'b1 || sata_busy !== 1'b0 || cmd_status !== 8'h50) begin
            errors++;
            $display("FAIL early_term: got done=%b err=%b busy=%b status=%h need 1 1 0 50",
                     cmd_done, cmd_error, sata_busy, cmd_status);
        end
        tick();
    endtask

    task automatic test_enable_abort;
        bit seen_done;
        seen_done = 1'b0;
        issue(8'h25, 48'h0000_0000_0300, 16'd1);
        pass_fis();
        rd_strobe = 1'b1;
        repeat (5) tick();
        rd_strobe = 1'b0;
        enable = 1'b0;
        tick();
        checks++;
        if (sata_busy !== 1'b0 || fis_tx_valid !== 1'b0 || cmd_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs: got busy=%b valid=%b done=%b need 0 0 0", sata_busy, fis_tx_valid, cmd_done);
        end
        enable = 1'b1;
        tick();
        checks++;
        if (cmd_done !== 1'b0 || sata_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: got done=%b busy=%b need 0 0", cmd_done, sata_busy);
        end
        fis_tx_ready = 1'b1;
        issue(8'h35, 48'h0000_0000_2000, 16'd1);
        checks++;
        if (fis_tx_valid !== 1'b1 || fis_tx_data !== 32'h0035_8027) begin
            errors++;
            $display("FAIL abort_fresh_fis: got valid=%b data=%h need 1 00358027", fis_tx_valid, fis_tx_data);
        end
        pass_fis();
        wr_strobe = 1'b1;
        repeat (128) tick();
        wr_strobe = 1'b0;
        tick();
        d2h_valid  = 1'b1;
        d2h_status = 8'h50;
        d2h_error  = 8'h00;
        for (int i = 0; i < 10 && !seen_done; i++) begin
            tick();
            d2h_valid = 1'b0;
            if (cmd_done === 1'b1) seen_done = 1'b1;
        end
        d2h_valid = 1'b0;
        checks++;
        if (!seen_done || cmd_error !== 1'b0) begin
            errors++;
            $display("FAIL abort_fresh_done: got done_seen=%b err=%b need 1 0", seen_done, cmd_error);
        end
        tick();
    endtask

    initial begin
        rst                      = 1'b1;
        enable                   = 1'b1;
        sata_command             = 8'h00;
        sata_execute_command_stb = 1'b0;
        sata_lba                 = 48'd0;
        sata_sector_count        = 16'd0;
        fis_tx_ready             = 1'b0;
        wr_strobe                = 1'b0;
        rd_strobe                = 1'b0;
        d2h_valid                = 1'b0;
        d2h_status               = 8'h00;
        d2h_error                = 8'h00;
        test_reset();
        test_write();
        test_read_max();
        test_final_strobe_with_status();
        test_random_ready();
        test_early_term();
        test_enable_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
